// File: rtl/pc_fetch_unit.sv
// ============================================================================
//  Module      : pc_fetch_unit
//  Description : Holds the architectural PC, loads npc on retire, fetches the
//                instruction at PC over a valid/ready imem port for decode.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      npc,
    input  logic             pc_update,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [31:0]      imem_addr,
    input  logic             imem_resp_valid,
    input  logic [31:0]      imem_resp_data,
    output logic             inst_valid,
    output logic [31:0]      inst,
    output logic [31:0]      inst_pc,
    output logic             inst_fault,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [1:0] c_st_req   = 2'd0;
    localparam logic [1:0] c_st_wait  = 2'd1;
    localparam logic [1:0] c_st_hold  = 2'd2;
    localparam logic [1:0] c_st_fault = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [31:0]      r_pc;
    logic [31:0]      r_inst;
    logic             r_drop;
    logic             w_drop_nxt;
    logic [CNT_W-1:0] r_fetch_count;
    logic             w_accept;
    logic             w_deliver;
    logic [1:0]       w_npc_target;

    assign w_accept     = imem_req_valid && imem_req_ready;
    // A misaligned target never issues a request; it parks in FAULT instead.
    assign w_npc_target = (npc[1:0] != 2'b00) ? c_st_fault : c_st_req;

    always_comb begin
        w_state_nxt = r_state;
        w_drop_nxt  = r_drop;
        w_deliver   = 1'b0;
        case (r_state)
            c_st_req: begin
                if (w_accept) begin
                    w_state_nxt = c_st_wait;
                    // The accepted address is already stale if pc moves now.
                    if (pc_update) w_drop_nxt = 1'b1;
                end else if (pc_update) begin
                    w_state_nxt = w_npc_target;
                end
            end
            c_st_wait: begin
                if (pc_update) begin
                    if (imem_resp_valid) begin
                        w_state_nxt = w_npc_target;
                        w_drop_nxt  = 1'b0;
                    end else begin
                        w_drop_nxt  = 1'b1;
                    end
                end else if (imem_resp_valid) begin
                    if (r_drop) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = (r_pc[1:0] != 2'b00) ? c_st_fault : c_st_req;
                    end else begin
                        w_deliver   = 1'b1;
                        w_state_nxt = c_st_hold;
                    end
                end
            end
            c_st_hold, c_st_fault: begin
                if (pc_update) w_state_nxt = w_npc_target;
            end
            default: w_state_nxt = c_st_req;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_req;
            r_pc          <= RESET_PC;
            r_inst        <= 32'h0000_0000;
            r_drop        <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_drop  <= w_drop_nxt;
            if (pc_update) r_pc <= npc;
            if (w_deliver) begin
                r_inst        <= imem_resp_data;
                r_fetch_count <= r_fetch_count + 1'b1;
            end
        end
    end

    // Request is suppressed while reset is held even though state reads REQ.
    assign imem_req_valid = (r_state == c_st_req) && !rst;
    assign imem_addr      = r_pc;
    assign inst_valid     = (r_state == c_st_hold) || (r_state == c_st_fault);
    assign inst_fault     = (r_state == c_st_fault);
    assign inst           = (r_state == c_st_fault) ? NOP_INST : r_inst;
    assign inst_pc        = r_pc;
    assign fetch_count    = r_fetch_count;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ============================================================================
//  Module      : tb_pc_fetch_unit
//  Description : Directed self-checking bench for pc_fetch_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] npc;
    logic        pc_update;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic [31:0] fetch_count;

    int r_tests = 0;
    int r_fails = 0;

    pc_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (32),
        .NOP_INST (32'h0000_0013)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .npc             (npc),
        .pc_update       (pc_update),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_fault      (inst_fault),
        .fetch_count     (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        r_tests++;
        assert (obs === exp) else begin
            r_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst             = 1'b1;
        npc             = 32'h0;
        pc_update       = 1'b0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;

        // Reset values
        step();
        step();
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_inst_fault", {31'b0, inst_fault}, 32'd0);
        check("rst_inst", inst, 32'h0);
        check("rst_count", fetch_count, 32'd0);
        check("rst_addr", imem_addr, 32'h0);

        // First fetch from RESET_PC
        rst = 1'b0;
        #1;
        check("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("first_addr", imem_addr, 32'h0);
        step();
        check("wait_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("wait_inst_valid", {31'b0, inst_valid}, 32'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0050_0093;
        step();
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        check("first_inst_valid", {31'b0, inst_valid}, 32'd1);
        check("first_inst", inst, 32'h0050_0093);
        check("first_inst_pc", inst_pc, 32'h0);
        check("first_count", fetch_count, 32'd1);
        check("first_fault", {31'b0, inst_fault}, 32'd0);
        step();
        check("hold_inst", inst, 32'h0050_0093);
        check("hold_valid", {31'b0, inst_valid}, 32'd1);

        // Retire from HOLD to 0x40
        pc_update = 1'b1;
        npc       = 32'h40;
        step();
        pc_update = 1'b0;
        check("upd_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("upd_addr", imem_addr, 32'h40);
        check("upd_inst_valid", {31'b0, inst_valid}, 32'd0);
        step();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h1111_1111;
        step();
        imem_resp_valid = 1'b0;
        check("i40_inst", inst, 32'h1111_1111);
        check("i40_pc", inst_pc, 32'h40);
        check("i40_count", fetch_count, 32'd2);

        // Redirect while WAIT; stale response discarded
        pc_update = 1'b1;
        npc       = 32'h60;
        step();
        pc_update = 1'b0;
        step();
        pc_update = 1'b1;
        npc       = 32'h80;
        step();
        pc_update = 1'b0;
        check("stale_wait_req", {31'b0, imem_req_valid}, 32'd0);
        check("stale_wait_addr", imem_addr, 32'h80);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        step();
        imem_resp_valid = 1'b0;
        check("stale_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("stale_addr", imem_addr, 32'h80);
        check("stale_count", fetch_count, 32'd2);
        check("stale_inst_valid", {31'b0, inst_valid}, 32'd0);
        step();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h2222_2222;
        step();
        imem_resp_valid = 1'b0;
        check("i80_inst", inst, 32'h2222_2222);
        check("i80_pc", inst_pc, 32'h80);
        check("i80_count", fetch_count, 32'd3);

        // Misaligned target -> FAULT
        pc_update = 1'b1;
        npc       = 32'h102;
        step();
        pc_update = 1'b0;
        check("fault_valid", {31'b0, inst_valid}, 32'd1);
        check("fault_flag", {31'b0, inst_fault}, 32'd1);
        check("fault_inst", inst, 32'h0000_0013);
        check("fault_req", {31'b0, imem_req_valid}, 32'd0);
        check("fault_pc", inst_pc, 32'h102);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h3333_3333;
        step();
        imem_resp_valid = 1'b0;
        check("fault_stray_count", fetch_count, 32'd3);
        check("fault_stray_flag", {31'b0, inst_fault}, 32'd1);
        pc_update = 1'b1;
        npc       = 32'h104;
        imem_req_ready = 1'b0;
        step();
        pc_update = 1'b0;
        check("unfault_req", {31'b0, imem_req_valid}, 32'd1);
        check("unfault_addr", imem_addr, 32'h104);
        check("unfault_flag", {31'b0, inst_fault}, 32'd0);
        check("unfault_valid", {31'b0, inst_valid}, 32'd0);

        // Backpressure: request held stable
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_req", {31'b0, imem_req_valid}, 32'd1);
            check("bp_addr", imem_addr, 32'h104);
        end
        imem_req_ready = 1'b1;
        step();
        check("bp_accept", {31'b0, imem_req_valid}, 32'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h4444_4444;
        step();
        imem_resp_valid = 1'b0;
        check("i104_inst", inst, 32'h4444_4444);
        check("i104_count", fetch_count, 32'd4);

        // Redirect on the same edge as accept -> drop
        pc_update = 1'b1;
        npc       = 32'h200;
        step();
        npc       = 32'h300;
        step();
        pc_update = 1'b0;
        check("acc_upd_req", {31'b0, imem_req_valid}, 32'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h5555_5555;
        step();
        imem_resp_valid = 1'b0;
        check("acc_upd_addr", imem_addr, 32'h300);
        check("acc_upd_reqv", {31'b0, imem_req_valid}, 32'd1);
        check("acc_upd_count", fetch_count, 32'd4);

        // Response and redirect on the same edge -> discard
        step();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h6666_6666;
        pc_update       = 1'b1;
        npc             = 32'h400;
        step();
        imem_resp_valid = 1'b0;
        pc_update       = 1'b0;
        check("same_edge_count", fetch_count, 32'd4);
        check("same_edge_addr", imem_addr, 32'h400);
        check("same_edge_req", {31'b0, imem_req_valid}, 32'd1);
        check("same_edge_valid", {31'b0, inst_valid}, 32'd0);
        step();

        // Reset while WAIT; late response ignored
        rst = 1'b1;
        step();
        check("rst2_req", {31'b0, imem_req_valid}, 32'd0);
        check("rst2_count", fetch_count, 32'd0);
        rst             = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h7777_7777;
        step();
        imem_resp_valid = 1'b0;
        check("rst2_addr", imem_addr, 32'h0);
        check("rst2_reqv", {31'b0, imem_req_valid}, 32'd1);
        check("rst2_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst2_count_after", fetch_count, 32'd0);
        imem_req_ready = 1'b1;
        step();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h8888_8888;
        step();
        imem_resp_valid = 1'b0;
        check("rst2_inst", inst, 32'h8888_8888);
        check("rst2_final_count", fetch_count, 32'd1);

        $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
        $finish;
    end

endmodule

`default_nettype wire
